// File: rtl/lsu_mem_ctrl.sv
// LSU memory-access stage: effective address, req/ack data-memory transaction, load align/extend, writeback.
// Optional macro LSU_TIMEOUT_EN aborts a request with bus_err after TIMEOUT_CYCLES unacknowledged REQ cycles.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_load,
    input  logic        zero_ext,
    input  logic        is_nop,
    input  logic [1:0]  size,
    input  logic [4:0]  rd,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [11:0] imm,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_exc,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t             state;
    logic signed [31:0] imm_sx_p0;
    logic [31:0]        ea_p0;
    logic               aligned_p0;
    logic               accept_p0;
    logic               timeout_hit;

    logic [1:0]         size_p1;
    logic [1:0]         ea_lo_p1;
    logic               zext_p1;
    logic               load_p1;
    logic [4:0]         rd_p1;

    function automatic logic aligned_chk(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   aligned_chk = 1'b1;
            2'b01:   aligned_chk = ~lo[0];
            default: aligned_chk = (lo == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] be_gen(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   be_gen = 4'b0001 << lo;
            2'b01:   be_gen = lo[1] ? 4'b1100 : 4'b0011;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_gen(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   wdata_gen = {4{d[7:0]}};
            2'b01:   wdata_gen = {2{d[15:0]}};
            default: wdata_gen = d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] rdata, input logic [1:0] sz,
                                             input logic [1:0] lo, input logic zx);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (sz)
            2'b00:   load_ext = zx ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = zx ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_ext = rdata;
        endcase
    endfunction

    // p0: accept-cycle address generation and alignment check
    assign imm_sx_p0  = {{20{imm[11]}}, imm};
    assign ea_p0      = rs1_val + imm_sx_p0;
    assign aligned_p0 = aligned_chk(size, ea_p0[1:0]);
    assign accept_p0  = (state != REQ) && !is_nop;

    // Gated by rst_n so a held op on the inputs cannot stall upstream during reset.
    assign stall = rst_n && ((accept_p0 && aligned_p0) ||
                             ((state == REQ) && !mem_ack && !timeout_hit));

    // p1: op fields captured at accept, consumed when the ack arrives
    always_ff @(posedge clk) begin
        if (accept_p0 && aligned_p0) begin
            size_p1  <= size;
            ea_lo_p1 <= ea_p0[1:0];
            zext_p1  <= zero_ext;
            load_p1  <= is_load;
            rd_p1    <= rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_be       <= 4'd0;
            mem_wdata    <= 32'd0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'd0;
            misalign_exc <= 1'b0;
        end else begin
            misalign_exc <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                    if (accept_p0) begin
                        if (aligned_p0) begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= ~is_load;
                            mem_addr  <= {ea_p0[31:2], 2'b00};
                            mem_be    <= be_gen(size, ea_p0[1:0]);
                            mem_wdata <= wdata_gen(size, rs2_val);
                        end else begin
                            misalign_exc <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // p2: read data is aligned and extended straight into the writeback register
                    if (mem_ack) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        wb_valid <= load_p1;
                        if (load_p1) begin
                            wb_rd   <= rd_p1;
                            wb_data <= load_ext(mem_rdata, size_p1, ea_lo_p1, zext_p1);
                        end
                    end else if (timeout_hit) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    logic [CNT_W-1:0] tmo_cnt;

    // Counter sits at zero outside REQ, so every request starts counting from zero.
    assign timeout_hit = (state == REQ) && !mem_ack &&
                         (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= timeout_hit;
            if (state != REQ) begin
                tmo_cnt <= '0;
            end else if (!mem_ack) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: stimulus queues expected memory/writeback/exception events, a monitor pops them.
module tb_lsu_mem_ctrl;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    localparam int K_REQ  = 1;
    localparam int K_WB   = 2;
    localparam int K_MIS  = 3;
    localparam int K_BERR = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        is_load, zero_ext, is_nop;
    logic [1:0]  size;
    logic [4:0]  rd;
    logic [31:0] rs1_val, rs2_val;
    logic [11:0] imm;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_exc, bus_err;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        we;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic req_prev = 1'b0;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .is_load(is_load), .zero_ext(zero_ext), .is_nop(is_nop),
        .size(size), .rd(rd), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic we);
        exp_t e;
        e.kind = kind; e.a = a; e.d = d; e.be = be; e.we = we;
        q.push_back(e);
    endtask

    task automatic check_event(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d, expected none", kind);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            if (e.kind == kind) begin
                case (kind)
                    K_REQ: begin
                        chk("req_addr", mem_addr, e.a);
                        chk("req_we", {31'd0, mem_we}, {31'd0, e.we});
                        chk("req_be", {28'd0, mem_be}, {28'd0, e.be});
                        if (e.we) chk("req_wdata", mem_wdata, e.d);
                    end
                    K_WB: begin
                        chk("wb_rd", {27'd0, wb_rd}, e.a);
                        chk("wb_data", wb_data, e.d);
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // Monitor: samples on the falling edge, one event check per presented output
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req && !req_prev) check_event(K_REQ);
            if (wb_valid)             check_event(K_WB);
            if (misalign_exc)         check_event(K_MIS);
            if (bus_err)              check_event(K_BERR);
        end
        req_prev = mem_req;
    end

    // Drives one aligned op, holds it while stalled, acks after dly wait cycles; returns in the RESP cycle.
    task automatic issue_op(input logic ld, input logic zx, input logic [1:0] sz, input logic [4:0] r,
                            input logic [31:0] a, input logic [31:0] d, input logic [11:0] im,
                            input int dly, input logic [31:0] rdat,
                            input logic [31:0] x_addr, input logic [3:0] x_be,
                            input logic [31:0] x_wd, input logic [31:0] x_wb);
        push(K_REQ, x_addr, x_wd, x_be, ~ld);
        if (ld) push(K_WB, {27'd0, r}, x_wb, 4'd0, 1'b0);
        is_load = ld; zero_ext = zx; size = sz; rd = r;
        rs1_val = a; rs2_val = d; imm = im; is_nop = 1'b0;
        @(negedge clk);
        chk("accept_stall", {31'd0, stall}, 32'd1);
        chk("accept_no_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("req_hold", {31'd0, mem_req}, 32'd1);
            chk("req_stall", {31'd0, stall}, 32'd1);
            @(posedge clk); #1;
        end
        mem_ack = 1'b1;
        mem_rdata = rdat;
        @(negedge clk);
        chk("ack_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        is_nop = 1'b1;
    endtask

    task automatic issue_misaligned(input logic [1:0] sz, input logic [31:0] a);
        push(K_MIS, 32'd0, 32'd0, 4'd0, 1'b0);
        is_load = 1'b1; zero_ext = 1'b0; size = sz; rd = 5'd9;
        rs1_val = a; rs2_val = 32'd0; imm = 12'd0; is_nop = 1'b0;
        @(negedge clk);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        chk("mis_no_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        is_nop = 1'b1;
        @(negedge clk);
        chk("mis_no_req_after", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis_pulse_end", {31'd0, misalign_exc}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_be"}, {28'd0, mem_be}, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_wbrd"}, {27'd0, wb_rd}, 32'd0);
        chk({tag, "_wbdata"}, wb_data, 32'd0);
        chk({tag, "_mis"}, {31'd0, misalign_exc}, 32'd0);
        chk({tag, "_berr"}, {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cnt;
        // Reset with an aligned op sitting on the inputs: stall must still be 0
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        is_load = 1'b1; zero_ext = 1'b0; is_nop = 1'b0; size = 2'b10; rd = 5'd1;
        rs1_val = 32'h100; rs2_val = 32'd0; imm = 12'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        is_nop = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Signed byte load at ea 0xFFF
        issue_op(1'b1, 1'b0, 2'b00, 5'd5, 32'h1000, 32'd0, 12'hFFF, 2, 32'h80000000,
                 32'h00000FFC, 4'b1000, 32'd0, 32'hFFFFFF80);
        @(posedge clk); #1;

        // Half store to upper lane; wb_* must keep the previous load result
        issue_op(1'b0, 1'b0, 2'b01, 5'd6, 32'h2002, 32'h0000BEEF, 12'h000, 1, 32'd0,
                 32'h00002000, 4'b1100, 32'hBEEFBEEF, 32'd0);
        @(negedge clk);
        chk("store_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("wb_data_hold", wb_data, 32'hFFFFFF80);
        chk("wb_rd_hold", {27'd0, wb_rd}, 32'd5);
        @(posedge clk); #1;

        issue_misaligned(2'b10, 32'h3001);
        issue_misaligned(2'b01, 32'h3003);

        // Back-to-back zero-extended half loads; the second is accepted in RESP
        issue_op(1'b1, 1'b1, 2'b01, 5'd7, 32'h4000, 32'd0, 12'h002, 0, 32'h80011234,
                 32'h00004000, 4'b1100, 32'd0, 32'h00008001);
        issue_op(1'b1, 1'b1, 2'b01, 5'd8, 32'h4000, 32'd0, 12'h004, 1, 32'hFFFF9876,
                 32'h00004004, 4'b0011, 32'd0, 32'h00009876);

        // Word load, signed upper half load, byte store, size 11 store, zero-extended byte load
        issue_op(1'b1, 1'b0, 2'b10, 5'd10, 32'h5000, 32'd0, 12'h7FC, 0, 32'hDEADBEEF,
                 32'h000057FC, 4'b1111, 32'd0, 32'hDEADBEEF);
        issue_op(1'b1, 1'b0, 2'b01, 5'd11, 32'h6000, 32'd0, 12'hFFE, 3, 32'h87650000,
                 32'h00005FFC, 4'b1100, 32'd0, 32'hFFFF8765);
        issue_op(1'b0, 1'b0, 2'b00, 5'd12, 32'h7000, 32'h123456A5, 12'h001, 0, 32'd0,
                 32'h00007000, 4'b0010, 32'hA5A5A5A5, 32'd0);
        issue_op(1'b0, 1'b0, 2'b11, 5'd13, 32'h8000, 32'hCAFEF00D, 12'h000, 1, 32'd0,
                 32'h00008000, 4'b1111, 32'hCAFEF00D, 32'd0);
        issue_op(1'b1, 1'b1, 2'b00, 5'd14, 32'h9000, 32'd0, 12'h000, 0, 32'h000000F0,
                 32'h00009000, 4'b0001, 32'd0, 32'h000000F0);
        @(posedge clk); #1;

        // Reset while a request is outstanding
        push(K_REQ, 32'h0000B000, 32'd0, 4'b1111, 1'b0);
        is_load = 1'b1; zero_ext = 1'b0; size = 2'b10; rd = 5'd3;
        rs1_val = 32'hB000; rs2_val = 32'd0; imm = 12'd0; is_nop = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        is_nop = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_rst");
        @(posedge clk); #1;

`ifdef LSU_TIMEOUT_EN
        // No ack: mem_req high for exactly TMO cycles, then a bus_err pulse
        push(K_REQ, 32'h0000A000, 32'h11223344, 4'b1111, 1'b1);
        push(K_BERR, 32'd0, 32'd0, 4'd0, 1'b0);
        is_load = 1'b0; size = 2'b10; rs1_val = 32'hA000; rs2_val = 32'h11223344;
        imm = 12'd0; is_nop = 1'b0;
        req_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 4) is_nop = 1'b1;
            @(negedge clk);
            if (mem_req) req_cnt++;
            if (i == 3) chk("tmo_stall_release", {31'd0, stall}, 32'd0);
            if (i == 5) chk("tmo_berr_pulse_end", {31'd0, bus_err}, 32'd0);
        end
        chk("tmo_req_cycles", req_cnt, TMO);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
